prefetch_dma_responder: RTL
===========================

// Module: prefetch_dma_responder
// PURPOSE
//  Serves the responder end of the stream prefetcher's DMA path. It accepts prefetch
//  requests (addresses), issues one memory read at a time, and holds the returned
//  words in a small fully-associative fill buffer. It then answers cache lookups
//  against that buffer. Sits between stream_prefetcher and the cache DMA / memory side.
// PARAMETERS
//  addr_width_p  32  address width
//  data_width_p  32  fill word width
//  els_p         4   fill-buffer entries; power of 2, >=2
// PORTS
//  clk_i             in   1             clock
//  reset_i           in   1             reset
//  pf_req_v_i        in   1             prefetch request valid
//  pf_req_addr_i     in   addr_width_p  prefetch address
//  pf_req_ready_o    out  1             request accepted when v&ready
//  dma_req_v_o       out  1             memory read request valid
//  dma_req_addr_o    out  addr_width_p  memory read address
//  dma_req_yumi_i    in   1             memory consumes request this cycle
//  dma_data_v_i      in   1             read data valid
//  dma_data_i        in   data_width_p  read data
//  dma_data_ready_o  out  1             data accepted when v&ready
//  lookup_v_i        in   1             cache lookup valid
//  lookup_addr_i     in   addr_width_p  lookup address
//  lookup_v_o        out  1             lookup result valid (1 cycle after lookup_v_i)
//  lookup_hit_o      out  1             lookup hit
//  lookup_data_o     out  data_width_p  hit data; 0 on miss
// BEHAVIOUR
//  - One clock (clk_i); reset_i is synchronous, active-high.
//  - Reset: all entries FREE, FSM IDLE. All outputs 0 except pf_req_ready_o, which is 1.
//  - Entry state (per entry): FREE, ALLOC, INFLIGHT, VALID, plus a kill bit and addr/data regs.
//  - pf_req_ready_o = any FREE entry, computed from registered state; full -> 0, no eviction.
//  - Accepting a request:
//    - the lowest-index FREE entry -> ALLOC with the address;
//    - if the address matches any non-FREE entry, the request is accepted and dropped (no alloc).
//  - Issue FSM, one read outstanding:
//    - IDLE: if any ALLOC entry -> latch the lowest-index ALLOC entry, go to REQ.
//    - REQ: dma_req_v_o=1, dma_req_addr_o=entry addr. Addr is stable until yumi.
//      On dma_req_yumi_i: entry -> INFLIGHT, go to WAIT.
//    - WAIT: dma_data_ready_o=1. On dma_data_v_i: entry -> VALID with data, or -> FREE
//      if kill is set; go to IDLE.
//    - dma_data_ready_o=0 outside WAIT.
//    - Minimum turnaround: IDLE -> REQ -> WAIT -> IDLE = 3 cycles per read.
//  - Lookup: addr compared against all entries in the lookup_v_i cycle; result registered
//    (1-cycle latency).
//    - VALID match: lookup_hit_o=1, data returned, entry -> FREE next cycle.
//    - ALLOC match: miss; entry -> FREE (cancel). If it is the REQ-latched entry, REQ completes
//      normally and kill is set on entry.
//    - INFLIGHT match: miss; kill set.
//    - No match: miss.
//  - Simultaneous events:
//    - Data return and INFLIGHT lookup on the same entry, same cycle: miss, entry -> FREE.
//    - Entry freed this cycle is not allocatable until next cycle.
//    - Request and lookup with equal address, same cycle: request dropped as duplicate
//      only if an entry already exists; the new ALLOC is not seen by that lookup.
//  - Address compare is full-width, exact. At most one entry matches any address (dup-drop).
//  - Reset mid-read: state cleared immediately. Memory must not return data for pre-reset
//    requests; stray data is not consumed (ready=0).
// STRUCTURE
//  - Shared package stream_prefetch_pkg: entry-state enum (FREE/ALLOC/INFLIGHT/VALID),
//    FSM enum (IDLE/REQ/WAIT), entry struct typedef.
//  - Sub-module prefetch_entry_cam: parallel addr compare -> one-hot match vector +
//    lowest-index FREE/ALLOC select. Used by the request, issue and lookup paths.
//  - Top: entry array regs, issue FSM, lookup output regs.
// TESTING
//  - Reset, then req 0x100 -> dma_req_addr_o=0x100 2 cycles later.
//    yumi, data 0xCAFE; lookup 0x100 -> hit, 0xCAFE next cycle; second lookup -> miss.
//  - Fill 4 entries (0x0,0x40,0x80,0xC0) while memory stalls yumi -> ready drops to 0.
//    Service one and hit it -> ready returns to 1.
//  - Req 0x200 twice -> single dma read; only one entry occupied.
//  - Req 0x300, lookup 0x300 while INFLIGHT -> miss. Data returns -> entry FREE;
//    later lookup 0x300 misses.
//  - Lookup 0x400 in the same cycle its data returns -> miss; occupancy decrements.
//  - Assert reset_i while in WAIT -> next cycle FSM IDLE, all entries FREE,
//    dma_data_ready_o=0, pf_req_ready_o=1.

Source files
------------

// File: rtl/stream_prefetch_pkg.sv
// Shared types for the stream prefetcher DMA responder: entry lifecycle,
// issue FSM states and the per-entry bookkeeping record.
package stream_prefetch_pkg;

    typedef enum logic [1:0] {
        EntFree     = 2'd0,
        EntAlloc    = 2'd1,
        EntInflight = 2'd2,
        EntValid    = 2'd3
    } entry_state_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } issue_state_e;

    // Kill marks an entry whose read must be discarded when its data returns.
    typedef struct packed {
        entry_state_e state;
        logic         kill;
    } entry_meta_t;

    localparam entry_meta_t EntryReset = '{state: EntFree, kill: 1'b0};

endpackage

// File: rtl/prefetch_entry_cam.sv
// Parallel address compare over the fill buffer plus lowest-index selection
// of a FREE entry (for allocation) and an ALLOC entry (for issue).
module prefetch_entry_cam
    import stream_prefetch_pkg::*;
#(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned els_p        = 4,
    localparam int unsigned idx_width_lp = $clog2(els_p)
) (
    input  entry_meta_t             meta [els_p],
    input  logic [addr_width_p-1:0] addr [els_p],
    input  logic [addr_width_p-1:0] req_addr,
    input  logic                    lookup_v,
    input  logic [addr_width_p-1:0] lookup_addr,
    output logic [els_p-1:0]        lookup_match,
    output logic                    req_dup,
    output logic                    free_any,
    output logic [idx_width_lp-1:0] free_idx,
    output logic                    alloc_any,
    output logic [idx_width_lp-1:0] alloc_idx
);

    always_comb begin
        lookup_match = '0;
        req_dup      = 1'b0;
        free_any     = 1'b0;
        free_idx     = '0;
        alloc_any    = 1'b0;
        alloc_idx    = '0;
        // Walk high to low so the last hit left standing is the lowest index.
        for (int i = int'(els_p) - 1; i >= 0; i--) begin
            if (meta[i].state == EntFree) begin
                free_any = 1'b1;
                free_idx = idx_width_lp'(i);
            end else begin
                if (addr[i] == lookup_addr) begin
                    lookup_match[i] = 1'b1;
                end
                if (addr[i] == req_addr) begin
                    req_dup = 1'b1;
                end
            end
            // An ALLOC entry being cancelled by a lookup this cycle must not be issued.
            if (meta[i].state == EntAlloc && !(lookup_v && addr[i] == lookup_addr)) begin
                alloc_any = 1'b1;
                alloc_idx = idx_width_lp'(i);
            end
        end
    end

endmodule

// File: rtl/prefetch_dma_responder.sv
// Responder end of the prefetch DMA path: allocates fill-buffer entries for
// prefetch requests, issues one memory read at a time and answers lookups.
module prefetch_dma_responder
    import stream_prefetch_pkg::*;
#(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned els_p        = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    pf_req_v_i,
    input  logic [addr_width_p-1:0] pf_req_addr_i,
    output logic                    pf_req_ready_o,
    output logic                    dma_req_v_o,
    output logic [addr_width_p-1:0] dma_req_addr_o,
    input  logic                    dma_req_yumi_i,
    input  logic                    dma_data_v_i,
    input  logic [data_width_p-1:0] dma_data_i,
    output logic                    dma_data_ready_o,
    input  logic                    lookup_v_i,
    input  logic [addr_width_p-1:0] lookup_addr_i,
    output logic                    lookup_v_o,
    output logic                    lookup_hit_o,
    output logic [data_width_p-1:0] lookup_data_o
);

    localparam int unsigned idx_width_lp = $clog2(els_p);

    entry_meta_t             meta_q [els_p];
    entry_meta_t             meta_d [els_p];
    logic [addr_width_p-1:0] addr_q [els_p];
    logic [addr_width_p-1:0] addr_d [els_p];
    logic [data_width_p-1:0] data_q [els_p];
    logic [data_width_p-1:0] data_d [els_p];

    issue_state_e            state_q, state_d;
    logic [idx_width_lp-1:0] sel_q, sel_d;

    logic                    lookup_v_q;
    logic                    lookup_hit_q, lookup_hit_d;
    logic [data_width_p-1:0] lookup_data_q, lookup_data_d;

    logic [els_p-1:0]        lookup_match;
    logic                    req_dup;
    logic                    free_any;
    logic [idx_width_lp-1:0] free_idx;
    logic                    alloc_any;
    logic [idx_width_lp-1:0] alloc_idx;

    prefetch_entry_cam #(
        .addr_width_p(addr_width_p),
        .els_p       (els_p)
    ) u_cam (
        .meta        (meta_q),
        .addr        (addr_q),
        .req_addr    (pf_req_addr_i),
        .lookup_v    (lookup_v_i),
        .lookup_addr (lookup_addr_i),
        .lookup_match(lookup_match),
        .req_dup     (req_dup),
        .free_any    (free_any),
        .free_idx    (free_idx),
        .alloc_any   (alloc_any),
        .alloc_idx   (alloc_idx)
    );

    assign pf_req_ready_o   = free_any;
    assign dma_req_v_o      = (state_q == StReq);
    assign dma_req_addr_o   = (state_q == StReq) ? addr_q[sel_q] : '0;
    assign dma_data_ready_o = (state_q == StWait);

    always_comb begin
        meta_d        = meta_q;
        addr_d        = addr_q;
        data_d        = data_q;
        state_d       = state_q;
        sel_d         = sel_q;
        lookup_hit_d  = 1'b0;
        lookup_data_d = '0;

        // Request path sees only registered state, so a slot freed this cycle waits.
        if (pf_req_v_i && free_any && !req_dup) begin
            meta_d[free_idx] = '{state: EntAlloc, kill: 1'b0};
            addr_d[free_idx] = pf_req_addr_i;
        end

        if (lookup_v_i) begin
            for (int i = 0; i < int'(els_p); i++) begin
                if (lookup_match[i]) begin
                    case (meta_q[i].state)
                        EntValid: begin
                            lookup_hit_d    = 1'b1;
                            lookup_data_d   = data_q[i];
                            meta_d[i].state = EntFree;
                        end
                        EntAlloc: begin
                            // The entry already presented to memory must see its read through.
                            if (state_q == StReq && sel_q == idx_width_lp'(i)) begin
                                meta_d[i].kill = 1'b1;
                            end else begin
                                meta_d[i].state = EntFree;
                            end
                        end
                        EntInflight: meta_d[i].kill = 1'b1;
                        default: ;
                    endcase
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (alloc_any) begin
                    sel_d   = alloc_idx;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (dma_req_yumi_i) begin
                    meta_d[sel_q].state = EntInflight;
                    state_d             = StWait;
                end
            end
            StWait: begin
                if (dma_data_v_i) begin
                    if (meta_d[sel_q].kill) begin
                        meta_d[sel_q] = EntryReset;
                    end else begin
                        meta_d[sel_q].state = EntValid;
                        data_d[sel_q]       = dma_data_i;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(els_p); i++) begin
                meta_q[i] <= EntryReset;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            state_q       <= StIdle;
            sel_q         <= '0;
            lookup_v_q    <= 1'b0;
            lookup_hit_q  <= 1'b0;
            lookup_data_q <= '0;
        end else begin
            meta_q        <= meta_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            state_q       <= state_d;
            sel_q         <= sel_d;
            lookup_v_q    <= lookup_v_i;
            lookup_hit_q  <= lookup_hit_d;
            lookup_data_q <= lookup_data_d;
        end
    end

    assign lookup_v_o    = lookup_v_q;
    assign lookup_hit_o  = lookup_hit_q;
    assign lookup_data_o = lookup_data_q;

endmodule
